// File: rtl/par_inject_arbiter_if.sv
// Bus bundle between the traffic sources, the injection arbiter and the router local input port.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

interface par_inject_arbiter_if #(
    parameter int NUM_SRC = 4
);
    localparam int W = `PAYLOAD_SIZE + `ADDR_BITS;

    logic [NUM_SRC*W-1:0] items_in;
    logic [NUM_SRC-1:0]   valid_in;
    logic [NUM_SRC-1:0]   send;
    logic [NUM_SRC-1:0]   busy_out;
    logic [W-1:0]         item_out;
    logic                 valid_out;
    logic                 busy_in;

    // Sources pulse valid_in for one cycle, ideally only while send is high.
    // Router side: an item moves on every cycle with valid_out & !busy_in;
    // while busy_in holds, item_out/valid_out stay frozen.
    modport master (
        output items_in, valid_in, busy_in,
        input  send, busy_out, item_out, valid_out
    );
    modport slave (
        input  items_in, valid_in, busy_in,
        output send, busy_out, item_out, valid_out
    );
endinterface

// File: rtl/par_inject_arbiter.sv
// Round-robin injection arbiter: per-source one-entry capture slots feeding a
// registered router output, throttled by a periodically refilled credit bucket.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

module par_inject_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int PERIOD     = 16,
    parameter int CREDIT_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    par_inject_arbiter_if.slave   bus,
    output logic [NUM_SRC-1:0]    overflow,
    output logic [15:0]           tx_count
);
    localparam int W  = `PAYLOAD_SIZE + `ADDR_BITS;
    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [3:0]    CMAX  = 4'(CREDIT_MAX);
    localparam logic [CW-1:0] PLAST = CW'(PERIOD - 1);

    logic [W-1:0]         slot_data [NUM_SRC];
    logic [NUM_SRC-1:0]   slot_full;
    logic [PW-1:0]        rr_ptr;
    logic [CW-1:0]        period_cnt;
    logic [3:0]           credits;
    logic [W-1:0]         item_q;
    logic                 valid_q;

    logic                 transfer;
    logic                 load;
    logic                 refill;
    logic                 grant_found;
    logic [PW-1:0]        grant;
    logic [PW-1:0]        idx;
    logic [NUM_SRC-1:0]   drain;

    assign transfer     = valid_q & ~bus.busy_in;
    assign refill       = (period_cnt == PLAST);
    assign load         = (~valid_q | transfer) & (credits != 4'd0) & grant_found;
    assign bus.item_out  = item_q;
    assign bus.valid_out = valid_q;
    assign bus.busy_out  = slot_full;
    assign bus.send      = {NUM_SRC{enable}} & ~slot_full;

    // First full slot at or after rr_ptr, wrapping around the source list.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        idx         = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = PW'((int'(rr_ptr) + k) % NUM_SRC);
            if (!grant_found && slot_full[idx]) begin
                grant_found = 1'b1;
                grant       = idx;
            end
        end
    end

    always_comb begin
        drain = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            drain[i] = load && (grant == PW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_full  <= '0;
            overflow   <= '0;
            rr_ptr     <= '0;
            period_cnt <= '0;
            credits    <= CMAX;
            item_q     <= '0;
            valid_q    <= 1'b0;
            tx_count   <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                slot_data[i] <= '0;
            end
        end else begin
            // A draining slot accepts a new item in the same cycle; the old one goes out.
            for (int i = 0; i < NUM_SRC; i++) begin
                if (bus.valid_in[i] && (!slot_full[i] || drain[i])) begin
                    slot_data[i] <= bus.items_in[i*W +: W];
                    slot_full[i] <= 1'b1;
                end else if (drain[i]) begin
                    slot_full[i] <= 1'b0;
                end
                if (bus.valid_in[i] && slot_full[i] && !drain[i]) begin
                    overflow[i] <= 1'b1;
                end
            end

            if (load) begin
                item_q  <= slot_data[grant];
                valid_q <= 1'b1;
                rr_ptr  <= (grant == PW'(NUM_SRC - 1)) ? '0 : grant + PW'(1);
            end else if (transfer) begin
                valid_q <= 1'b0;
            end

            period_cnt <= refill ? '0 : period_cnt + CW'(1);

            if (load && !refill) begin
                credits <= credits - 4'd1;
            end else if (refill && !load && credits != CMAX) begin
                credits <= credits + 4'd1;
            end

            if (transfer) begin
                tx_count <= tx_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_par_inject_arbiter.sv
// Self-checking bench for par_inject_arbiter: scoreboarded item flow on a fast-refill
// instance, and injection-rate timing on a CREDIT_MAX=2 / PERIOD=4 instance.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

module tb_par_inject_arbiter;
    localparam int W  = `PAYLOAD_SIZE + `ADDR_BITS;
    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [NS-1:0] ovf_a, ovf_b;
    logic [15:0]   tx_a, tx_b;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            xfer_a  = 0;
    bit            sb_on   = 1'b1;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  exp_item;

    par_inject_arbiter_if #(.NUM_SRC(NS)) bus_a ();
    par_inject_arbiter_if #(.NUM_SRC(NS)) bus_b ();

    par_inject_arbiter #(.NUM_SRC(NS), .PERIOD(1), .CREDIT_MAX(4)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .bus(bus_a),
        .overflow(ovf_a), .tx_count(tx_a)
    );

    par_inject_arbiter #(.NUM_SRC(NS), .PERIOD(4), .CREDIT_MAX(2)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .bus(bus_b),
        .overflow(ovf_b), .tx_count(tx_b)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus_a.valid_in = '0;
        bus_b.valid_in = '0;
        bus_a.busy_in  = 1'b0;
        bus_b.busy_in  = 1'b0;
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver helpers
    function automatic logic [NS*W-1:0] place(input int src, input logic [W-1:0] item);
        logic [NS*W-1:0] v;
        v = '0;
        v[src*W +: W] = item;
        return v;
    endfunction

    task automatic drive(input logic [NS-1:0] mask, input logic [NS*W-1:0] items);
        bus_a.valid_in = mask;
        bus_a.items_in = items;
        step();
        bus_a.valid_in = '0;
    endtask

    // scoreboard: every router-side transfer pops the oldest expected item
    always @(negedge clk) begin
        if (!reset && bus_a.valid_out && !bus_a.busy_in) begin
            xfer_a++;
            if (sb_on) begin
                if (exp_q.size() == 0) begin
                    check("sb_extra", 32'(bus_a.item_out), 32'hFFFF_FFFF);
                end else begin
                    exp_item = exp_q.pop_front();
                    check("sb_item", 32'(bus_a.item_out), 32'(exp_item));
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int src;
        int base;
        bit mid_done;
        int tx_t[$];
        logic [3:0] burst;
        logic [W-1:0] item;

        enable         = 1'b1;
        bus_a.items_in = '0;
        bus_b.items_in = '0;
        do_reset();

        // reset state
        check("rst_busy",  32'(bus_a.busy_out), 32'h0);
        check("rst_send",  32'(bus_a.send), 32'hF);
        check("rst_valid", 32'(bus_a.valid_out), 32'h0);
        check("rst_item",  32'(bus_a.item_out), 32'h0);
        check("rst_ovf",   32'(ovf_a), 32'h0);
        check("rst_tx",    32'(tx_a), 32'h0);
        enable = 1'b0;
        #1;
        check("send_disabled", 32'(bus_a.send), 32'h0);
        enable = 1'b1;

        // single source latency
        exp_q.push_back(12'h413);
        drive(4'b0001, place(0, 12'h413));
        check("s1_busy",  32'(bus_a.busy_out), 32'h1);
        check("s1_send",  32'(bus_a.send), 32'hE);
        check("s1_early", 32'(bus_a.valid_out), 32'h0);
        step();
        check("s1_valid", 32'(bus_a.valid_out), 32'h1);
        check("s1_item",  32'(bus_a.item_out), 32'h413);
        check("s1_freed", 32'(bus_a.busy_out), 32'h0);
        step();
        check("s1_tx",    32'(tx_a), 32'h1);
        check("s1_idle",  32'(bus_a.valid_out), 32'h0);

        // round-robin over four simultaneous captures
        do_reset();
        exp_q.push_back(12'h101);
        exp_q.push_back(12'h202);
        exp_q.push_back(12'h303);
        exp_q.push_back(12'h404);
        drive(4'hF, {12'h404, 12'h303, 12'h202, 12'h101});
        check("rr_busy", 32'(bus_a.busy_out), 32'hF);
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr_valid", 32'(bus_a.valid_out), 32'h1);
        end
        step();
        check("rr_done",  32'(bus_a.valid_out), 32'h0);
        check("rr_tx",    32'(tx_a), 32'h4);
        check("rr_drain", 32'(exp_q.size()), 32'h0);

        // backpressure; src0 wins again because the pointer wrapped to 0
        bus_a.busy_in = 1'b1;
        exp_q.push_back(12'h0A1);
        exp_q.push_back(12'h1B2);
        drive(4'b0011, {12'h000, 12'h000, 12'h1B2, 12'h0A1});
        step();
        for (int k = 0; k < 10; k++) begin
            check("bp_item",  32'(bus_a.item_out), 32'h0A1);
            check("bp_valid", 32'(bus_a.valid_out), 32'h1);
            check("bp_send1", 32'(bus_a.send[1]), 32'h0);
            step();
        end
        // release together with a capture into the slot being granted
        bus_a.busy_in = 1'b0;
        exp_q.push_back(12'h1C3);
        drive(4'b0010, place(1, 12'h1C3));
        check("bp_next_item",  32'(bus_a.item_out), 32'h1B2);
        check("bp_next_valid", 32'(bus_a.valid_out), 32'h1);
        check("cg_slot_kept",  32'(bus_a.busy_out[1]), 32'h1);
        check("cg_no_ovf",     32'(ovf_a), 32'h0);
        step();
        check("cg_new_item",   32'(bus_a.item_out), 32'h1C3);
        check("cg_slot_free",  32'(bus_a.busy_out[1]), 32'h0);
        step();
        check("bp_idle",  32'(bus_a.valid_out), 32'h0);
        check("bp_drain", 32'(exp_q.size()), 32'h0);

        // overflow: output occupied, slot 2 pulsed twice two cycles apart
        bus_a.busy_in = 1'b1;
        exp_q.push_back(12'h0D0);
        drive(4'b0001, place(0, 12'h0D0));
        step();
        exp_q.push_back(12'h2C1);
        drive(4'b0100, place(2, 12'h2C1));
        step();
        drive(4'b0100, place(2, 12'h2C2));
        check("ovf_set",  32'(ovf_a), 32'h4);
        check("ovf_busy", 32'(bus_a.busy_out[2]), 32'h1);
        step();
        check("ovf_sticky", 32'(ovf_a), 32'h4);
        bus_a.busy_in = 1'b0;
        repeat (3) step();
        check("ovf_sticky2", 32'(ovf_a), 32'h4);
        check("ovf_drain",   32'(exp_q.size()), 32'h0);
        check("ovf_idle",    32'(bus_a.valid_out), 32'h0);

        // reset mid-operation with an item parked on the output
        bus_a.busy_in = 1'b1;
        drive(4'b1000, place(3, 12'h3E3));
        step();
        check("pre_rst_valid", 32'(bus_a.valid_out), 32'h1);
        reset = 1'b1;
        step();
        check("mrst_ovf",   32'(ovf_a), 32'h0);
        check("mrst_valid", 32'(bus_a.valid_out), 32'h0);
        check("mrst_item",  32'(bus_a.item_out), 32'h0);
        check("mrst_busy",  32'(bus_a.busy_out), 32'h0);
        reset = 1'b0;
        bus_a.busy_in = 1'b0;
        step();
        check("mrst_tx", 32'(tx_a), 32'h0);

        // random single-source traffic with random backpressure: order must hold
        src = $urandom_range(0, NS - 1);
        for (int c = 0; c < 300; c++) begin
            bus_a.busy_in = ($urandom_range(0, 3) == 0);
            if (bus_a.send[src] && ($urandom_range(0, 1) == 1)) begin
                item = {4'(src), 8'($urandom_range(0, 255))};
                exp_q.push_back(item);
                bus_a.valid_in[src] = 1'b1;
                bus_a.items_in      = place(src, item);
            end
            step();
            bus_a.valid_in = '0;
        end
        bus_a.busy_in = 1'b0;
        repeat (8) step();
        check("rnd_drain", 32'(exp_q.size()), 32'h0);
        check("rnd_ovf",   32'(ovf_a), 32'h0);

        // rate limit on dut_b: all sources kept full
        do_reset();
        burst = '0;
        for (int t = 0; t < 80; t++) begin
            bus_b.busy_in = (t >= 40 && t < 60);
            bus_b.valid_in = bus_b.send;
            bus_b.items_in = {12'h4B4, 12'h3B3, 12'h2B2, 12'h1B1};
            if (bus_b.valid_out && !bus_b.busy_in) begin
                if (t < 40) tx_t.push_back(t);
                if (t >= 60 && t < 64) burst[63 - t] = 1'b1;
            end
            step();
        end
        bus_b.valid_in = '0;
        bus_b.busy_in  = 1'b0;
        check("rl_count",     32'(tx_t.size() >= 8), 32'h1);
        check("rl_first_gap", 32'(tx_t[1] - tx_t[0]), 32'h1);
        check("rl_second_gap", 32'((tx_t[2] - tx_t[1]) >= 2 && (tx_t[2] - tx_t[1]) <= 4), 32'h1);
        for (int k = 3; k < tx_t.size(); k++) begin
            check("rl_gap", 32'(tx_t[k] - tx_t[k-1]), 32'h4);
        end
        check("rl_burst", 32'(burst), 32'hE);
        check("rl_ovf",   32'(ovf_b), 32'h0);

        // tx_count wrap on dut_a
        sb_on = 1'b0;
        do_reset();
        base     = xfer_a;
        mid_done = 1'b0;
        for (int c = 0; c < 70000 && (xfer_a - base) < 65536; c++) begin
            bus_a.valid_in = bus_a.send;
            bus_a.items_in = {12'h444, 12'h333, 12'h222, 12'h111};
            step();
            if (!mid_done && (xfer_a - base) == 1000) begin
                check("wrap_mid", 32'(tx_a), 32'd1000);
                mid_done = 1'b1;
            end
        end
        bus_a.valid_in = '0;
        check("wrap_reached", 32'(xfer_a - base), 32'd65536);
        check("wrap_tx",      32'(tx_a), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/par_inject_arbiter.md
# par_inject_arbiter

Round-robin injection arbiter that shares one router injection port among `NUM_SRC` traffic sources (`par_source_*` instances). It gives each source a one-entry capture slot, because sources present `valid` as a single-cycle pulse. It then grants captured items to a registered output under a credit-based injection-rate limit. It sits between the per-node source instances and the router local input port.

## Interface
- `NUM_SRC`, default 4: number of sources, 2..8.
- `PERIOD`, default 16: cycles per credit refill; 1 means one credit every cycle.
- `CREDIT_MAX`, default 4: credit bucket ceiling, 1..15; also the credit value at reset.
- `W` (derived, not overridable) = `` `PAYLOAD_SIZE+`ADDR_BITS ``: item width.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: global injection enable.
- `items_in` in `NUM_SRC*W`: source i item at bits `[i*W +: W]`.
- `valid_in` in `NUM_SRC`: per-source valid pulse.
- `send` out `NUM_SRC`: per-source send enable.
- `busy_out` out `NUM_SRC`: per-source busy.
- `item_out` out W: item to the router.
- `valid_out` out 1: item valid to the router.
- `busy_in` in 1: router busy; a transfer occurs when `valid_out & !busy_in`.
- `overflow` out `NUM_SRC`: sticky per-source drop flag.
- `tx_count` out 16: accepted-transfer counter.

## Operation
- Slot i is loaded from the item and `slot_full[i]` is set when `valid_in[i]` is high while the slot is empty, or is being drained in the same cycle.
- A `valid_in[i]` pulse while slot i is full and not draining drops the item, sets `overflow[i]`, and leaves the slot contents unchanged.
- `busy_out[i] = slot_full[i]`. `send[i] = enable & !slot_full[i]`. Both are combinational from registered state.
- The output register can be loaded when `(!valid_out | transfer)` and `credits != 0` and any slot is full.
- Grant selection: the first full slot found scanning from `rr_ptr` upward, modulo `NUM_SRC`.
- On a load:
  - `item_out` <= the granted slot's item and `valid_out` <= 1.
  - The granted slot is cleared (drained).
  - Credits decrement by 1.
  - `rr_ptr` <= grant+1, wrapping to 0 after `NUM_SRC-1`.
- On a transfer with no load in the same cycle, `valid_out` <= 0.
- While `valid_out & busy_in`, `item_out` and `valid_out` hold stable.
- Credits:
  - `period_cnt` counts 0..`PERIOD-1` and wraps.
  - On wrap, credits increment, saturating at `CREDIT_MAX`.
  - A refill and a consume in the same cycle leave credits unchanged.
- `tx_count` increments on each transfer and wraps from 0xFFFF to 0.
- Dropping `enable` stops new `send` assertions only. Captured and output items still drain.

## Timing
- Reset values:
  - `slot_full` = 0, so `busy_out` = 0.
  - `send` = {`NUM_SRC`{`enable`}}.
  - `valid_out` = 0, `item_out` = 0.
  - `overflow` = 0, `tx_count` = 0, `rr_ptr` = 0, `period_cnt` = 0, credits = `CREDIT_MAX`.
- Latency:
  - `valid_in[i]` at cycle t gives `busy_out[i]` = 1 at t+1.
  - The earliest `valid_out` is at t+2, when credits are available and the output is free.
- Throughput: one item per cycle while credits last and `busy_in` = 0. Back-to-back loads occur on transfer cycles.
- Per-source ordering is preserved. Cross-source order follows round-robin only.
- Reset asserted mid-operation discards all slot and output contents on the next edge, with no partial transfer.
- A slot capture and the same slot's grant in the same cycle: the old item goes to the output and the new item stays in the slot.

## Test plan
Assume `` `PAYLOAD_SIZE=8 `` and `` `ADDR_BITS=4 ``.

- **Single source.** Reset, then pulse `valid_in[0]` with item 0x413 at cycle 5 -> `busy_out[0]`=1 at 6; `valid_out`=1 with `item_out`=0x413 at 7; `tx_count`=1 at 8; credits 3.
- **Round-robin.** All four slots are filled in the same cycle with 0x101/0x202/0x303/0x404 and `busy_in`=0 -> outputs in order src0, 1, 2, 3 on consecutive cycles; `rr_ptr`=0 after.
- **Backpressure.** Hold `busy_in`=1 for 10 cycles with an item on the output -> `item_out` is stable and `valid_out` stays 1. Source 1 slot stays full and `send[1]`=0. On release, the transfer occurs and the next grant loads in the same cycle.
- **Rate limit.** `CREDIT_MAX`=2, `PERIOD`=4, continuous refilling of all sources -> 2 immediate transfers, then exactly one transfer per 4 cycles. Credits never exceed 2.
- **Overflow.** Pulse `valid_in[2]` twice, two cycles apart, while `busy_in`=1 -> `overflow[2]`=1 sticky and the first item is delivered. Then assert `reset` -> `overflow` is 0 and `valid_out` is 0 next edge.
- **Wrap.** Run 65536 transfers -> `tx_count` returns to 0.
